midi_rx_sched: RTL

- Services up to NUM_CH midi_rx receivers that share one read bus and merges their bytes into a single byte stream for the router core.
- Arbitrates irq requests round-robin and reads each byte over the bus.
- Tracks MIDI message framing and locks to one channel for a whole message, so messages from different inputs never interleave on the output.
- Realtime bytes pass through without disturbing the lock.

---
 rtl/midi_pkg.sv | 34 +++
 rtl/midi_rr_arb.sv | 45 ++++
 rtl/midi_rx_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared encodings for the MIDI receive scheduler: FSM states, status byte ranges
// and the data-byte count that follows a status byte.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_READ  = 2'd1,
    ST_GUARD = 2'd2,
    ST_PUSH  = 2'd3
  } state_t;

  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;

  function automatic logic [1:0] data_len(input logic [7:0] status);
    logic [1:0] n;
    n = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
      4'hC, 4'hD:                   n = 2'd1;
      4'hF: begin
        if (status == 8'hF1 || status == 8'hF3) begin
          n = 2'd1;
        end else if (status == 8'hF2) begin
          n = 2'd2;
        end
      end
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_rr_arb.sv
// Round-robin arbiter: combinational grant of the first request at or above the pointer,
// wrapping; the pointer moves past a serviced channel when upd_en is pulsed.
module midi_rr_arb #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              upd_en,
  input  logic [2:0]        upd_idx,
  output logic              gnt_vld,
  output logic [2:0]        gnt_idx
);

  logic [2:0] ptr_q, ptr_d;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    for (int off = 0; off < NUM_CH; off++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!gnt_vld && req[i] && (i == (int'(ptr_q) + off) % NUM_CH)) begin
          gnt_vld = 1'b1;
          gnt_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_en) begin
      ptr_d = (upd_idx == 3'(NUM_CH - 1)) ? 3'd0 : upd_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/midi_rx_sched.sv
// Merges bytes from NUM_CH midi_rx receivers into one framed stream; irq to out_valid is
// 3 cycles minimum, and a stalled out_ready holds the FSM in PUSH with no further bus reads.
module midi_rx_sched
  import midi_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter logic [15:0] TIMEOUT_CYC = 16'd48000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq,
  output logic [7:0]        bus_addr,
  output logic              bus_rd,
  input  logic [7:0]        bus_dat,
  output logic [7:0]        out_dat,
  output logic [2:0]        out_ch,
  output logic              out_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_abort,
  output logic              lock_active
);

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [7:0]        byte_q, byte_d;
  logic [NUM_CH-1:0] guard_q, guard_d;
  logic              lock_q, lock_d;
  logic [2:0]        lock_ch_q, lock_ch_d;
  logic              sysex_q, sysex_d;
  logic [1:0]        rem_q, rem_d;
  logic              rel_q, rel_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [7:0]        rs_q [NUM_CH];
  logic [7:0]        rs_d [NUM_CH];

  logic              bus_rd_q, bus_rd_d;
  logic [7:0]        bus_addr_q, bus_addr_d;
  logic [7:0]        out_dat_q, out_dat_d;
  logic [2:0]        out_ch_q, out_ch_d;
  logic              out_sof_q, out_sof_d;
  logic              out_valid_q, out_valid_d;
  logic              out_abort_q, out_abort_d;

  logic [NUM_CH-1:0] lock_mask;
  logic [NUM_CH-1:0] req;
  logic              gnt_vld;
  logic [2:0]        gnt_idx;
  logic              arb_upd;

  logic              rs_wr;
  logic [2:0]        rs_wr_ch;
  logic [7:0]        rs_wr_val;
  logic [7:0]        cur_rs;

  // While a message is locked only its own channel may be arbitrated.
  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (3'(i) == lock_ch_q) lock_mask[i] = 1'b1;
    end
    req = irq & ~guard_q;
    if (lock_q) req = req & lock_mask;
  end

  assign arb_upd = (state_q == ST_READ);

  midi_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .upd_en  (arb_upd),
    .upd_idx (grant_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    byte_d      = byte_q;
    guard_d     = guard_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    sysex_d     = sysex_q;
    rem_d       = rem_q;
    rel_d       = rel_q;
    tmo_d       = tmo_q;
    rs_d        = rs_q;
    bus_rd_d    = 1'b0;
    bus_addr_d  = bus_addr_q;
    out_dat_d   = out_dat_q;
    out_ch_d    = out_ch_q;
    out_sof_d   = out_sof_q;
    out_valid_d = out_valid_q;
    out_abort_d = 1'b0;
    rs_wr       = 1'b0;
    rs_wr_ch    = grant_q;
    rs_wr_val   = 8'h00;
    cur_rs      = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (3'(i) == grant_q) cur_rs = rs_q[i];
    end

    case (state_q)
      ST_ARB: begin
        guard_d = '0;
        if (gnt_vld) begin
          grant_d    = gnt_idx;
          bus_rd_d   = 1'b1;
          bus_addr_d = BASE_ADDR + {5'd0, gnt_idx};
          state_d    = ST_READ;
        end else if (lock_q) begin
          if (tmo_q + 16'd1 >= TIMEOUT_CYC) begin
            lock_d      = 1'b0;
            sysex_d     = 1'b0;
            rem_d       = 2'd0;
            tmo_d       = 16'd0;
            out_abort_d = 1'b1;
            rs_wr       = 1'b1;
            rs_wr_ch    = lock_ch_q;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end else begin
          tmo_d = 16'd0;
        end
      end

      ST_READ: begin
        byte_d  = bus_dat;
        tmo_d   = 16'd0;
        state_d = ST_GUARD;
        for (int i = 0; i < NUM_CH; i++) begin
          guard_d[i] = (3'(i) == grant_q);
        end
      end

      ST_GUARD: begin
        out_valid_d = 1'b1;
        out_dat_d   = byte_q;
        out_ch_d    = grant_q;
        out_sof_d   = 1'b0;
        rel_d       = 1'b0;
        state_d     = ST_PUSH;
        if (byte_q >= REALTIME_MIN) begin
          out_sof_d = 1'b1;
        end else if (byte_q[7]) begin
          out_sof_d = (byte_q != SYSEX_END);
          rs_wr     = 1'b1;
          rs_wr_val = (byte_q < SYSEX_START) ? byte_q : 8'h00;
          rem_d     = data_len(byte_q);
          // Status bytes with nothing to follow (F4..F7) end any lock once pushed.
          if (byte_q <= SYSEX_START || data_len(byte_q) != 2'd0) begin
            lock_d    = 1'b1;
            lock_ch_d = grant_q;
            sysex_d   = (byte_q == SYSEX_START);
          end else begin
            rel_d = 1'b1;
          end
        end else if (!lock_q) begin
          if (cur_rs != 8'h00) begin
            out_sof_d = 1'b1;
            lock_d    = 1'b1;
            lock_ch_d = grant_q;
            sysex_d   = 1'b0;
            rem_d     = data_len(cur_rs) - 2'd1;
            rel_d     = (data_len(cur_rs) == 2'd1);
          end
        end else if (!sysex_q) begin
          rem_d = (rem_q == 2'd0) ? 2'd0 : rem_q - 2'd1;
          rel_d = (rem_q <= 2'd1);
        end
      end

      ST_PUSH: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ARB;
          rel_d       = 1'b0;
          if (rel_q) begin
            lock_d  = 1'b0;
            sysex_d = 1'b0;
            rem_d   = 2'd0;
          end
        end
      end

      default: state_d = ST_ARB;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      if (rs_wr && 3'(i) == rs_wr_ch) rs_d[i] = rs_wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ARB;
      grant_q     <= 3'd0;
      byte_q      <= 8'h00;
      guard_q     <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= 3'd0;
      sysex_q     <= 1'b0;
      rem_q       <= 2'd0;
      rel_q       <= 1'b0;
      tmo_q       <= 16'd0;
      for (int i = 0; i < NUM_CH; i++) rs_q[i] <= 8'h00;
      bus_rd_q    <= 1'b0;
      bus_addr_q  <= 8'h00;
      out_dat_q   <= 8'h00;
      out_ch_q    <= 3'd0;
      out_sof_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      byte_q      <= byte_d;
      guard_q     <= guard_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      sysex_q     <= sysex_d;
      rem_q       <= rem_d;
      rel_q       <= rel_d;
      tmo_q       <= tmo_d;
      rs_q        <= rs_d;
      bus_rd_q    <= bus_rd_d;
      bus_addr_q  <= bus_addr_d;
      out_dat_q   <= out_dat_d;
      out_ch_q    <= out_ch_d;
      out_sof_q   <= out_sof_d;
      out_valid_q <= out_valid_d;
      out_abort_q <= out_abort_d;
    end
  end

  assign bus_rd      = bus_rd_q;
  assign bus_addr    = bus_addr_q;
  assign out_dat     = out_dat_q;
  assign out_ch      = out_ch_q;
  assign out_sof     = out_sof_q;
  assign out_valid   = out_valid_q;
  assign out_abort   = out_abort_q;
  assign lock_active = lock_q;

endmodule
